edge_stream_host: RTL and testbench

- Host-side driver for the edge-detection chip's pixel bus.
- Reads a packed IMG_DIM x IMG_DIM image from an external synchronous image memory and streams it to the chip, PIX_PER_CYC pixels per cycle on consecutive cycles, marking the last word with load_end.
- Then collects the chip's serial edge_out bitstream, qualified by readable, packs the bits into IMG_DIM-bit rows and writes them to a result memory.
- Sits between system memory and the chip; it is the transmitting end of the chip's load interface and the receiving end of its result interface.

---
 rtl/edge_stream_host.sv | 180 ++++++++++++++++++
 tb/tb_edge_stream_host.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_stream_host.sv
// Host driver for the edge chip: streams an image out, packs result rows back.
// Optional capture watchdog: define EDGE_STREAM_HOST_TIMEOUT_EN.
module edge_stream_host #(
  parameter int IMG_DIM     = 20,
  parameter int BIT_LENGTH  = 5,
  parameter int PIX_PER_CYC = 5,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_re,
  output logic [6:0]                        mem_addr,
  input  logic [PIX_PER_CYC*BIT_LENGTH-1:0] mem_rdata,
  output logic [BIT_LENGTH-1:0]             pixel_out0,
  output logic [BIT_LENGTH-1:0]             pixel_out1,
  output logic [BIT_LENGTH-1:0]             pixel_out2,
  output logic [BIT_LENGTH-1:0]             pixel_out3,
  output logic [BIT_LENGTH-1:0]             pixel_out4,
  output logic                              load_end,
  input  logic                              edge_out,
  input  logic                              readable,
  output logic                              res_we,
  output logic [4:0]                        res_addr,
  output logic [IMG_DIM-1:0]                res_data,
  output logic                              error
);

  localparam int WW = PIX_PER_CYC * BIT_LENGTH;
  localparam int NWORDS = IMG_DIM * IMG_DIM / PIX_PER_CYC;
  localparam logic [6:0] LAST_WORD = 7'(NWORDS - 1);
  localparam logic [4:0] LAST_IDX = 5'(IMG_DIM - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, STREAM, CAPTURE, LAST, DONE
  } state_t;

  state_t state;

  logic [WW-1:0]      word_q;
  logic               rd_pend;
  logic [6:0]         rd_addr;
  logic [4:0]         col;
  logic [4:0]         row;
  logic [IMG_DIM-1:0] rowbuf;
  logic               to_fire;

  assign pixel_out0 = word_q[0*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out1 = word_q[1*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out2 = word_q[2*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out3 = word_q[3*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out4 = word_q[4*BIT_LENGTH +: BIT_LENGTH];

`ifdef EDGE_STREAM_HOST_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_ALL = '1;

  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 err_q;

  // Fires on the idle cycle that would take the counter to all-ones.
  assign to_fire = (state == CAPTURE) && !readable
                && (to_cnt == TO_ALL - TIMEOUT_W'(1));
  assign error = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && start)
        err_q <= 1'b0;
      else if (to_fire)
        err_q <= 1'b1;
      if (state != CAPTURE || readable)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TIMEOUT_W'(1);
    end
  end
`else
  assign to_fire = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      word_q   <= '0;
      load_end <= 1'b0;
      rd_pend  <= 1'b0;
      rd_addr  <= '0;
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      col      <= '0;
      row      <= '0;
      rowbuf   <= '0;
    end else begin
      res_we  <= 1'b0;
      rd_pend <= mem_re;
      rd_addr <= mem_addr;
      // Read data lands one cycle after the request; register it out.
      if (rd_pend) begin
        word_q   <= mem_rdata;
        load_end <= (rd_addr == LAST_WORD);
      end else begin
        word_q   <= '0;
        load_end <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            mem_re   <= 1'b1;
            mem_addr <= '0;
          end
        end
        FETCH: begin
          state    <= STREAM;
          mem_re   <= 1'b1;
          mem_addr <= 7'd1;
        end
        STREAM: begin
          if (mem_re) begin
            if (mem_addr == LAST_WORD)
              mem_re <= 1'b0;
            else
              mem_addr <= mem_addr + 7'd1;
          end
          if (load_end)
            state <= CAPTURE;
        end
        CAPTURE: begin
          if (to_fire) begin
            state  <= DONE;
            done   <= 1'b1;
            col    <= '0;
            rowbuf <= '0;
          end else if (readable) begin
            rowbuf[col] <= edge_out;
            if (col == LAST_IDX) begin
              col      <= '0;
              res_we   <= 1'b1;
              res_addr <= row;
              res_data <= {edge_out, rowbuf[IMG_DIM-2:0]};
              if (row == LAST_IDX)
                state <= LAST;
              else
                row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
          end
        end
        LAST: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          col    <= '0;
          row    <= '0;
          rowbuf <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_stream_host.sv
// Bench for edge_stream_host: memory model plus queue-free bit scoreboard.
// Builds with or without EDGE_STREAM_HOST_TIMEOUT_EN.
module tb_edge_stream_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_re, load_end;
  logic [6:0]  mem_addr;
  logic [24:0] mem_rdata = '0;
  logic [4:0]  p0, p1, p2, p3, p4;
  logic        edge_out = 1'b0;
  logic        readable = 1'b0;
  logic        res_we, error;
  logic [4:0]  res_addr;
  logic [19:0] res_data;

  int checks = 0;
  int errors = 0;

  logic [24:0] mem [80];

  edge_stream_host #(.TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .pixel_out0(p0), .pixel_out1(p1),
    .pixel_out2(p2), .pixel_out3(p3),
    .pixel_out4(p4), .load_end(load_end),
    .edge_out(edge_out), .readable(readable),
    .res_we(res_we), .res_addr(res_addr),
    .res_data(res_data), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_re && mem_addr < 7'd80)
      mem_rdata <= mem[mem_addr];

  task automatic fill_mem(input bit pattern);
    for (int k = 0; k < 80; k++) begin
      logic [4:0] v;
      v = 5'(k);
      mem[k] = pattern ? {5{v}} : 25'($urandom);
    end
  endtask

  // Starts a job and checks cycles S+1..S+83; returns in S+83 (CAPTURE).
  task automatic stream_job(input int poke_t);
    logic [24:0] ew;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= 83; t++) begin
      if (t > 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || mem_re !== (t <= 80)) begin
        errors++;
        $display("FAIL stream_ctl t=%0d busy=%b re=%b", t, busy, mem_re);
      end
      if (t <= 80) begin
        checks++;
        if (mem_addr !== 7'(t - 1)) begin
          errors++;
          $display("FAIL addr t=%0d got %0d want %0d", t, mem_addr, t - 1);
        end
      end
      ew = (t >= 3 && t <= 82) ? mem[t-3] : 25'd0;
      checks++;
      if ({p4, p3, p2, p1, p0} !== ew || load_end !== (t == 82)) begin
        errors++;
        $display("FAIL pixels t=%0d got %h/%b want %h/%b",
                 t, {p4, p3, p2, p1, p0}, load_end, ew, t == 82);
      end
      start = (t == poke_t);
      readable = (t <= 82) ? 1'($urandom_range(0, 1)) : 1'b0;
      edge_out = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
  endtask

  // mode 0: parity stream, 1: toggled readable with ones, 2: random.
  task automatic capture_job(input int mode, input int poke_c);
    bit bits [400];
    int nb = 0, nw = 0, ph = 0;
    logic exp_we = 1'b0;
    logic [19:0] er;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (res_we !== exp_we) begin
        errors++;
        $display("FAIL res_we c=%0d got %b want %b", c, res_we, exp_we);
      end
      if (exp_we) begin
        for (int i = 0; i < 20; i++) er[i] = bits[nw*20+i];
        checks++;
        if (res_addr !== 5'(nw) || res_data !== er) begin
          errors++;
          $display("FAIL row got %0d:%h want %0d:%h",
                   res_addr, res_data, nw, er);
        end
        nw++;
      end
      if (ph == 2) begin
        checks++;
        if ({done, busy} !== 2'b00) begin
          errors++;
          $display("FAIL idle_after got done/busy=%b%b want 00",
                   done, busy);
        end
        readable = 1'b0;
        start = 1'b0;
        return;
      end else if (ph == 1) begin
        checks++;
        if ({done, busy} !== 2'b11) begin
          errors++;
          $display("FAIL done_pulse got done/busy=%b%b want 11",
                   done, busy);
        end
        ph = 2;
      end else begin
        checks++;
        if ({done, busy, mem_re, error} !== 4'b0100) begin
          errors++;
          $display("FAIL capture_ctl c=%0d got %b want 0100",
                   c, {done, busy, mem_re, error});
        end
        if (nw == 20) ph = 1;
      end
      start = (c == poke_c);
      exp_we = 1'b0;
      edge_out = 1'($urandom_range(0, 1));
      if (nb < 400) begin
        case (mode)
          0: begin readable = 1'b1; edge_out = 1'(nb % 2); end
          1: begin readable = (c % 2 == 0); edge_out = 1'b1; end
          default: readable = 1'($urandom_range(0, 1));
        endcase
        if (readable) begin
          bits[nb] = edge_out;
          nb++;
          exp_we = (nb % 20 == 0);
        end
      end else begin
        readable = 1'b0;
      end
    end
    errors++;
    $display("FAIL capture_timeout rows got %0d want 20", nw);
    readable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mem_re, mem_addr, p0, p1, p2, p3, p4, load_end,
         res_we, res_addr, res_data, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs not all zero busy=%b re=%b addr=%0d",
               busy, mem_re, mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_parity();
    fill_mem(1'b1);
    stream_job(30);
    capture_job(0, 50);
  endtask

  task automatic test_toggle();
    fill_mem(1'b0);
    stream_job(0);
    capture_job(1, -1);
  endtask

  task automatic test_back_to_back();
    fill_mem(1'b0);
    stream_job(5);
    capture_job(2, 100);
  endtask

  task automatic test_abort();
    fill_mem(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (42) @(negedge clk);
    checks++;
    if ({p4, p3, p2, p1, p0} !== mem[40]) begin
      errors++;
      $display("FAIL abort_word40 got %h want %h",
               {p4, p3, p2, p1, p0}, mem[40]);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_re, mem_addr, p0, p1, p2, p3, p4, load_end,
         res_we, res_addr, res_data, error} !== '0) begin
      errors++;
      $display("FAIL abort_zero busy=%b re=%b addr=%0d le=%b",
               busy, mem_re, mem_addr, load_end);
    end
    reset = 1'b0;
    stream_job(0);
    capture_job(2, -1);
  endtask

  task automatic test_idle_capture();
    fill_mem(1'b0);
    stream_job(0);
`ifdef EDGE_STREAM_HOST_TIMEOUT_EN
    for (int i = 1; i <= 17; i++) begin
      if (i > 1) @(negedge clk);
      checks++;
      if (i <= 15 && {done, res_we, error, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL wd_wait i=%0d got %b want 0001",
                 i, {done, res_we, error, busy});
      end else if (i == 16 && {done, error, busy} !== 3'b111) begin
        errors++;
        $display("FAIL wd_fire got %b want 111", {done, error, busy});
      end else if (i == 17 && {done, error, busy} !== 3'b010) begin
        errors++;
        $display("FAIL wd_after got %b want 010", {done, error, busy});
      end
    end
`else
    for (int i = 1; i <= 1000; i++) begin
      if (i > 1) @(negedge clk);
      checks++;
      if ({done, res_we, error, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL no_wd i=%0d got %b want 0001",
                 i, {done, res_we, error, busy});
      end
    end
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_parity();
    test_toggle();
    test_back_to_back();
    test_abort();
    test_idle_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
